// File: rtl/writeback_unit.sv
// Write-back stage: in-order elastic queue of completed results, retired as a
// one-cycle register-file write / busy-release strobe. Optional WB_FORWARD_EN adds a forwarding search.
module writeback_unit #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  logic             mem_reg_write,
    input  logic             mem_to_reg,
    input  logic [4:0]       mem_rd,
    input  logic [31:0]      alu_data_out,
    input  logic [31:0]      mem_data_out,
    input  logic             wb_hold,
    output logic             reg_write,
    output logic [4:0]       reg_wr_addr_wb,
    output logic [31:0]      reg_wr_data,
    output logic [CNT_W-1:0] wb_count,
    output logic             wb_empty
`ifdef WB_FORWARD_EN
    ,
    input  logic [4:0]       fwd_query_addr,
    output logic             fwd_hit,
    output logic [31:0]      fwd_data
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [DEPTH-1:0][4:0]  rd_mem;
    logic [DEPTH-1:0][31:0] data_mem;

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             reg_write_q, reg_write_d;
    logic [4:0]       addr_q, addr_d;
    logic [31:0]      data_q, data_d;
    logic             push, pop;
    logic [31:0]      wr_data;

    assign mem_ready      = (count_q < DEPTH_C);
    assign wb_count       = count_q;
    assign wb_empty       = (count_q == '0);
    assign reg_write      = reg_write_q;
    assign reg_wr_addr_wb = addr_q;
    assign reg_wr_data    = data_q;
    assign wr_data        = mem_to_reg ? mem_data_out : alu_data_out;

    always_comb begin
        push        = mem_valid && mem_ready && mem_reg_write;
        pop         = (count_q != '0) && !wb_hold;
        head_d      = pop  ? head_q + PTR_W'(1) : head_q;
        tail_d      = push ? tail_q + PTR_W'(1) : tail_q;
        count_d     = count_q;
        if (push && !pop)
            count_d = count_q + CNT_W'(1);
        else if (pop && !push)
            count_d = count_q - CNT_W'(1);
        // r0 entries still drain the queue but never raise the strobe
        reg_write_d = pop && (rd_mem[head_q] != 5'd0);
        addr_d      = pop ? rd_mem[head_q]   : addr_q;
        data_d      = pop ? data_mem[head_q] : data_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            reg_write_q <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            reg_write_q <= reg_write_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
        end
    end

    // Storage needs no reset: occupancy is tracked solely by the pointers/count.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[tail_q]   <= mem_rd;
            data_mem[tail_q] <= wr_data;
        end
    end

`ifdef WB_FORWARD_EN
    // Scan oldest to youngest so the last hit wins; the live strobe is oldest of all.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (fwd_query_addr != 5'd0) begin
            if (reg_write_q && (addr_q == fwd_query_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if ((CNT_W'(i) < count_q) && (rd_mem[head_q + PTR_W'(i)] == fwd_query_addr)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = data_mem[head_q + PTR_W'(i)];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit (DEPTH=4).
module tb_writeback_unit;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             mem_valid = 1'b0;
    logic             mem_ready;
    logic             mem_reg_write = 1'b0;
    logic             mem_to_reg = 1'b0;
    logic [4:0]       mem_rd = '0;
    logic [31:0]      alu_data_out = '0;
    logic [31:0]      mem_data_out = '0;
    logic             wb_hold = 1'b0;
    logic             reg_write;
    logic [4:0]       reg_wr_addr_wb;
    logic [31:0]      reg_wr_data;
    logic [CNT_W-1:0] wb_count;
    logic             wb_empty;
`ifdef WB_FORWARD_EN
    logic [4:0]       fwd_query_addr = '0;
    logic             fwd_hit;
    logic [31:0]      fwd_data;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    writeback_unit #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_reg_write  (mem_reg_write),
        .mem_to_reg     (mem_to_reg),
        .mem_rd         (mem_rd),
        .alu_data_out   (alu_data_out),
        .mem_data_out   (mem_data_out),
        .wb_hold        (wb_hold),
        .reg_write      (reg_write),
        .reg_wr_addr_wb (reg_wr_addr_wb),
        .reg_wr_data    (reg_wr_data),
        .wb_count       (wb_count),
        .wb_empty       (wb_empty)
`ifdef WB_FORWARD_EN
        ,
        .fwd_query_addr (fwd_query_addr),
        .fwd_hit        (fwd_hit),
        .fwd_data       (fwd_data)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
        chk({tag, "_we"}, 32'(reg_write), 32'(we));
        chk({tag, "_addr"}, 32'(reg_wr_addr_wb), 32'(a));
        chk({tag, "_data"}, reg_wr_data, d);
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] md);
        mem_valid     = v;
        mem_reg_write = rw;
        mem_to_reg    = m2r;
        mem_rd        = rd;
        alu_data_out  = alu;
        mem_data_out  = md;
    endtask

    initial begin
        // reset state
        @(negedge clk);
        tick;
        strobe("rst", 1'b0, 5'd0, 32'h0);
        chk("rst_count", 32'(wb_count), 32'd0);
        chk("rst_empty", 32'(wb_empty), 32'd1);
        chk("rst_ready", 32'(mem_ready), 32'd1);
        reset = 1'b0;
        tick;

        // ALU result, one-edge latency, single-cycle strobe
        drive(1, 1, 0, 5'd5, 32'h11, 32'hDEADBEEF);
        tick;
        chk("alu_cnt1", 32'(wb_count), 32'd1);
        chk("alu_nolat", 32'(reg_write), 32'd0);
        drive(0, 0, 0, 5'd0, 32'h0, 32'h0);
        tick;
        strobe("alu", 1'b1, 5'd5, 32'h11);
        chk("alu_empty", 32'(wb_empty), 32'd1);
        tick;
        strobe("alu_hold", 1'b0, 5'd5, 32'h11);

        // load data select, then a non-writing instruction
        drive(1, 1, 1, 5'd3, 32'h99, 32'hCAFEF00D);
        tick;
        drive(0, 0, 0, 5'd0, 32'h0, 32'h0);
        tick;
        strobe("ld", 1'b1, 5'd3, 32'hCAFEF00D);
        drive(1, 0, 0, 5'd9, 32'h77, 32'h88);
        tick;
        chk("nowr_cnt", 32'(wb_count), 32'd0);
        chk("nowr_we", 32'(reg_write), 32'd0);
        drive(0, 0, 0, 5'd0, 32'h0, 32'h0);
        tick;
        chk("nowr_we2", 32'(reg_write), 32'd0);

        // fill under wb_hold, fifth waits, then drain in order
        wb_hold = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 0, 5'(10 + k), 32'h100 + 32'(k), 32'h0);
            tick;
            chk("fill_we", 32'(reg_write), 32'd0);
        end
        chk("full_cnt", 32'(wb_count), 32'd4);
        chk("full_ready", 32'(mem_ready), 32'd0);
        drive(1, 1, 0, 5'd14, 32'h104, 32'h0);
        tick;
        chk("full_cnt2", 32'(wb_count), 32'd4);
        chk("full_ready2", 32'(mem_ready), 32'd0);
        wb_hold = 1'b0;
        tick;
        strobe("drain0", 1'b1, 5'd10, 32'h100);
        chk("drain0_cnt", 32'(wb_count), 32'd3);
        chk("drain0_ready", 32'(mem_ready), 32'd1);
        tick;
        strobe("drain1", 1'b1, 5'd11, 32'h101);
        chk("drain1_cnt", 32'(wb_count), 32'd3);
        drive(0, 0, 0, 5'd0, 32'h0, 32'h0);
        tick;
        strobe("drain2", 1'b1, 5'd12, 32'h102);
        tick;
        strobe("drain3", 1'b1, 5'd13, 32'h103);
        tick;
        strobe("drain4", 1'b1, 5'd14, 32'h104);
        chk("drain_empty", 32'(wb_empty), 32'd1);
        tick;
        chk("drain_idle", 32'(reg_write), 32'd0);

        // r0 drains silently
        drive(1, 1, 0, 5'd0, 32'h1234, 32'h0);
        tick;
        drive(1, 1, 0, 5'd7, 32'h55, 32'h0);
        tick;
        chk("r0_we", 32'(reg_write), 32'd0);
        chk("r0_cnt", 32'(wb_count), 32'd1);
        drive(0, 0, 0, 5'd0, 32'h0, 32'h0);
        tick;
        strobe("r7", 1'b1, 5'd7, 32'h55);
        tick;
        chk("r7_idle", 32'(reg_write), 32'd0);

`ifdef WB_FORWARD_EN
        wb_hold = 1'b1;
        drive(1, 1, 0, 5'd9, 32'hA, 32'h0);
        tick;
        drive(1, 1, 0, 5'd9, 32'hB, 32'h0);
        tick;
        drive(0, 0, 0, 5'd0, 32'h0, 32'h0);
        fwd_query_addr = 5'd9;
        #1;
        chk("fwd_hit9", 32'(fwd_hit), 32'd1);
        chk("fwd_data9", fwd_data, 32'hB);
        fwd_query_addr = 5'd0;
        #1;
        chk("fwd_hit0", 32'(fwd_hit), 32'd0);
        chk("fwd_data0", fwd_data, 32'h0);
        fwd_query_addr = 5'd4;
        #1;
        chk("fwd_miss", 32'(fwd_hit), 32'd0);
        fwd_query_addr = 5'd9;
        wb_hold = 1'b0;
        tick;
        chk("fwd_q_young", fwd_data, 32'hB);
        tick;
        chk("fwd_strobe_hit", 32'(fwd_hit), 32'd1);
        chk("fwd_strobe_data", fwd_data, 32'hB);
        tick;
        chk("fwd_gone", 32'(fwd_hit), 32'd0);
        fwd_query_addr = 5'd0;
`endif

        // reset mid-operation with entries queued
        wb_hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 0, 5'(20 + k), 32'h200 + 32'(k), 32'h0);
            tick;
        end
        drive(0, 0, 0, 5'd0, 32'h0, 32'h0);
        chk("pre_rst_cnt", 32'(wb_count), 32'd3);
        #2 reset = 1'b1;
        #1;
        strobe("mid_rst", 1'b0, 5'd0, 32'h0);
        chk("mid_rst_cnt", 32'(wb_count), 32'd0);
        chk("mid_rst_empty", 32'(wb_empty), 32'd1);
        tick;
        reset = 1'b0;
        wb_hold = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick;
            chk("post_rst_we", 32'(reg_write), 32'd0);
            chk("post_rst_cnt", 32'(wb_count), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Write-back stage: the writer end of the decode-stage register-file write and scoreboard-release interface.
- Accepts completed results from the MEM stage and selects ALU or memory data.
- Buffers results in an in-order elastic queue.
- Retires one result per cycle as a single-cycle reg_write / reg_wr_addr_wb / reg_wr_data strobe. The instruction decoder uses this strobe to write the register file and clear the busy flag of the destination register.

Parameters:
- DEPTH, 4, number of queue entries; must be a power of 2 and at least 2.
- CNT_W, $clog2(DEPTH+1), width of wb_count.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- mem_valid  input  1  MEM stage presents a completed instruction.
- mem_ready  output  1  queue can accept an instruction this cycle.
- mem_reg_write  input  1  instruction writes a destination register.
- mem_to_reg  input  1  1 selects mem_data_out, 0 selects alu_data_out.
- mem_rd  input  5  destination register address.
- alu_data_out  input  32  ALU result.
- mem_data_out  input  32  load data.
- wb_hold  input  1  blocks retirement this cycle (register-file port conflict).
- reg_write  output  1  one-cycle register-file write and busy-flag release strobe.
- reg_wr_addr_wb  output  5  write address, valid while reg_write=1.
- reg_wr_data  output  32  write data, valid while reg_write=1.
- wb_count  output  CNT_W  number of occupied entries.
- wb_empty  output  1  wb_count==0.

Behaviour:
- Reset (asynchronous, active-high):
  - head and tail pointers and the count clear to 0; all queued entries are discarded.
  - reg_write=0, reg_wr_addr_wb=0, reg_wr_data=0, wb_count=0, wb_empty=1.
  - Reset asserted mid-operation drops all pending entries immediately, with no partial strobe.
- mem_ready is combinational and equals (wb_count < DEPTH).
  - When full, no push occurs even if a pop happens in the same cycle; mem_ready recovers the cycle after the pop.
- Accept:
  - A transfer occurs when mem_valid && mem_ready at a clock edge.
  - If mem_reg_write=1, push {mem_rd, mem_to_reg ? mem_data_out : alu_data_out} at tail; tail advances modulo DEPTH.
  - If mem_reg_write=0, the transfer completes but nothing is enqueued.
- Retire:
  - At each edge where the queue is non-empty and wb_hold=0, pop the head; head advances modulo DEPTH.
  - Registered outputs on the same edge: reg_write=1 (0 if the head entry's rd==0), reg_wr_addr_wb=rd, reg_wr_data=data.
  - Otherwise reg_write=0, and reg_wr_addr_wb / reg_wr_data hold their last values.
- Latency:
  - A result accepted into an empty queue at edge N appears on reg_write after edge N+1.
  - Push and pop never bypass each other within one edge.
- Ordering:
  - Strictly in-order retirement.
  - Two queued writes to the same rd produce two strobes in order, so the last write wins in the register file.
- Simultaneous push and pop: count unchanged; both pointers advance.
- wb_hold:
  - Only stalls retirement. Accepts continue until the queue is full.
  - Releasing wb_hold resumes retirement on the next edge.
- reg_write is never high for two cycles from one entry. Back-to-back entries give consecutive high cycles with different address/data.
- Writes to r0 are popped silently: no strobe, so r0 stays unflagged and zero.

Optional Feature:
- Macro WB_FORWARD_EN. When defined, it adds ports fwd_query_addr (input, 5), fwd_hit (output, 1) and fwd_data (output, 32).
- Forwarding search:
  - Combinational search over valid queued entries plus the current registered strobe.
  - fwd_hit=1 when any of these matches fwd_query_addr; fwd_data is the youngest match, where queued entries are younger than the strobe.
  - fwd_query_addr==0 gives fwd_hit=0 and fwd_data=0.
  - No match gives fwd_hit=0 and fwd_data=0.
- Without the macro these ports do not exist and no search logic is built.

Test Plan:
- Reset, then push rd=5, mem_to_reg=0, alu=0x00000011, mem=0xDEADBEEF -> after the next edge reg_write=1, addr=5, data=0x00000011 for exactly one cycle; wb_empty=1 afterwards.
- Push rd=3, mem_to_reg=1, mem=0xCAFEF00D -> strobe addr=3, data=0xCAFEF00D; push with mem_reg_write=0 -> wb_count unchanged, no strobe.
- Hold wb_hold=1 and push 5 results with DEPTH=4 -> mem_ready=0 after the 4th accept, the 5th waits; release wb_hold -> 4 consecutive strobes in order, then the 5th is accepted and retired.
- Push rd=0 data=0x1234, then rd=7 data=0x55 -> no strobe for r0; one strobe addr=7, data=0x55.
- Queue 3 entries with wb_hold=1, assert reset mid-cycle -> outputs 0 immediately, wb_count=0; after release no stale strobe appears.
- WB_FORWARD_EN: queue rd=9 data=0xA then rd=9 data=0xB with wb_hold=1, query 9 -> fwd_hit=1, fwd_data=0xB; query 0 -> fwd_hit=0.
